// File: rtl/mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_cache_ctrl
//  Purpose  : Direct-mapped, write-back / write-allocate cache controller.
//             Each line holds four 32-bit words, so a main-memory block is
//             128 bits. Controller states are IDLE, COMPARE, WRITEBACK and
//             ALLOCATE.
//  Ports    : clk, rst_n (async active-low)
//             cpuReq/cpuWrite/cpuAddr/cpuWriteData  -> request side
//             cpuReadData/cpuReady/cpuBusy          <- completion side
//             memWrite/memAddr/memWriteData         -> main-memory block port
//             memReadData                           <- fetched block
//             hitCount/missCount (CACHE_STATS_EN only) saturating counters
//  Options  : define CACHE_STATS_EN to add the hit/miss statistics outputs
//  Revision : 1.0  initial release
// ============================================================================
module mem_cache_ctrl #(
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpuReq,
  input  logic         cpuWrite,
  input  logic [9:0]   cpuAddr,
  input  logic [31:0]  cpuWriteData,
  output logic [31:0]  cpuReadData,
  output logic         cpuReady,
  output logic         cpuBusy,
  output logic         memWrite,
  output logic [9:0]   memAddr,
  output logic [127:0] memWriteData,
  input  logic [127:0] memReadData
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hitCount,
  output logic [15:0]  missCount
`endif
);

  localparam int         IDX_W    = $clog2(NUM_LINES);
  localparam int         TAG_W    = 6 - IDX_W;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t               state;
  logic                 req_write;
  logic [9:2]           req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           cnt;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [127:0]         lines [NUM_LINES];

  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             cnt_last;
  logic [31:0]      hit_word;
  logic             store_hit;
  logic             fill;
  logic             unused_addr_bits;

  assign req_off   = req_addr[3:2];
  assign req_idx   = req_addr[3+IDX_W:4];
  assign req_tag   = req_addr[9:4+IDX_W];
  assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);
  assign cnt_last  = (cnt == LAST_CNT);
  assign hit_word  = lines[req_idx][{req_off, 5'b0} +: 32];
  assign store_hit = (state == COMPARE) && hit && req_write;
  assign fill      = (state == ALLOCATE) && cnt_last;
  assign cpuBusy   = (state != IDLE);

  // Byte-within-word bits carry no meaning for word accesses.
  assign unused_addr_bits = ^cpuAddr[1:0];

  // Control FSM with registered outputs. cpuReady defaults low each cycle so
  // it can only ever be a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      cnt         <= '0;
      cpuReady    <= 1'b0;
      cpuReadData <= '0;
      memWrite    <= 1'b0;
      memAddr     <= '0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
    end else begin
      cpuReady <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuReq) begin
            req_write <= cpuWrite;
            req_addr  <= cpuAddr[9:2];
            req_wdata <= cpuWriteData;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_write) begin
              dirty[req_idx] <= 1'b1;
            end else begin
              cpuReadData <= hit_word;
            end
            cpuReady <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= '0;
            // Dirty implies valid; only a modified resident block is evicted.
            if (dirty[req_idx]) begin
              memWrite <= 1'b1;
              memAddr  <= {tags[req_idx], req_idx, 4'b0};
              state    <= WRITEBACK;
            end else begin
              memAddr  <= {req_tag, req_idx, 4'b0};
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (cnt_last) begin
            cnt      <= '0;
            memWrite <= 1'b0;
            memAddr  <= {req_tag, req_idx, 4'b0};
            state    <= ALLOCATE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ALLOCATE: begin
          if (cnt_last) begin
            cnt            <= '0;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            state          <= COMPARE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data/tag storage and the eviction buffer carry no reset. Reset forces the
  // FSM to IDLE asynchronously, which removes every write enable below.
  always_ff @(posedge clk) begin
    if (store_hit) begin
      lines[req_idx][{req_off, 5'b0} +: 32] <= req_wdata;
    end
    if (fill) begin
      lines[req_idx] <= memReadData;
      tags[req_idx]  <= req_tag;
    end
    if ((state == COMPARE) && !hit) begin
      memWriteData <= lines[req_idx];
    end
  end

`ifdef CACHE_STATS_EN
  // refill marks the COMPARE that follows an ALLOCATE so it is not counted.
  logic refill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill    <= 1'b0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if ((state == IDLE) && cpuReq) begin
        refill <= 1'b0;
      end
      if ((state == COMPARE) && !refill) begin
        if (hit) begin
          if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
        end else begin
          refill <= 1'b1;
          if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/mem_cache_ctrl.md
MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of direct-mapped lines (power of two, 2..16).
REQ-002 SHALL have parameter MEM_LATENCY, default 4, cycles per main-memory block transfer (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpuReq  input  1  request valid; sampled only in IDLE.
REQ-006 SHALL have port cpuWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port cpuAddr  input  10  byte address; bits [1:0] ignored.
REQ-008 SHALL have port cpuWriteData  input  32  store data.
REQ-009 SHALL have port cpuReadData  output  32  load data, valid while cpuReady high.
REQ-010 SHALL have port cpuReady  output  1  one-cycle completion pulse.
REQ-011 SHALL have port cpuBusy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port memWrite  output  1  1 = write block into main memory, 0 = read.
REQ-013 SHALL have port memAddr  output  10  block byte address, bits [3:0] always 0.
REQ-014 SHALL have port memWriteData  output  128  evicted block, word 0 in bits [31:0].
REQ-015 SHALL have port memReadData  input  128  fetched block, word 0 in bits [31:0].

Function
REQ-016 SHALL decode the address as word offset [3:2], index [3+log2(NUM_LINES):4] and tag in the remaining upper bits.
REQ-017 SHALL keep valid, dirty and tag bits plus four 32-bit data words per line (write-back, write-allocate).
REQ-018 SHALL implement FSM states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-019 IDLE: on a clock edge with cpuReq=1, SHALL latch cpuWrite, cpuAddr and cpuWriteData and go to COMPARE; cpuReq outside IDLE SHALL be ignored and not queued.
REQ-020 COMPARE, hit (valid and tag match): load SHALL register the word into cpuReadData; store SHALL write the word and set dirty; both SHALL pulse cpuReady for the following cycle and return to IDLE.
REQ-021 Hit latency SHALL be: request edge, then COMPARE edge, then cpuReady high in the next cycle.
REQ-022 COMPARE, miss with a dirty line SHALL go to WRITEBACK; a miss with a clean or invalid line SHALL go to ALLOCATE.
REQ-023 WRITEBACK SHALL drive memWrite=1, memAddr={old tag, index, 4'b0} and memWriteData=line for exactly MEM_LATENCY cycles, then go to ALLOCATE.
REQ-024 ALLOCATE SHALL drive memWrite=0 and memAddr={new tag, index, 4'b0} for MEM_LATENCY cycles; on the last edge it SHALL load memReadData and set valid=1, dirty=0 and tag, then go to COMPARE, which then hits.
REQ-025 A single cycle counter SHALL time WRITEBACK and ALLOCATE and clear on every state entry.
REQ-026 memWrite SHALL be 0 in every state except WRITEBACK; memWriteData SHALL be don't-care outside WRITEBACK.
REQ-027 cpuReady SHALL be 0 except for the single completion cycle; cpuReadData SHALL hold its last value otherwise.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, all valid and dirty bits 0, counter 0, cpuReady 0, cpuBusy 0, memWrite 0, memAddr 0 and cpuReadData 0.
REQ-029 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transfer with no completion pulse; data arrays need no reset.

Configuration
REQ-030 With macro CACHE_STATS_EN defined, SHALL add outputs hitCount[15:0] and missCount[15:0], both saturating at 0xFFFF and reset to 0.
REQ-031 Each request SHALL increment exactly one counter: a hit if its first COMPARE hits, otherwise a miss; the post-ALLOCATE COMPARE SHALL NOT count.
REQ-032 Without CACHE_STATS_EN, the counters and ports SHALL be absent and all other behaviour SHALL be identical.

Verification (main memory word i initialised to i; defaults)
REQ-033 Reset, load 0x004 -> ALLOCATE with memAddr=0x000 for 4 cycles, then cpuReady with cpuReadData=0x00000001.
REQ-034 Then load 0x008 -> hit, cpuReady 2 cycles after the request edge, data 0x00000002, memWrite stays 0.
REQ-035 Store 0x00C=0xDEADBEEF, then load 0x10C -> WRITEBACK memWrite=1, memAddr=0x000 and memWriteData[127:96]=0xDEADBEEF for 4 cycles, then ALLOCATE memAddr=0x100, then data 0x00000043.
REQ-036 Assert rst_n low during the second WRITEBACK cycle -> memWrite 0 and cpuBusy 0 immediately, no cpuReady; a following load 0x10C -> miss, no WRITEBACK.
REQ-037 Pulse cpuReq with a different address while cpuBusy=1 -> ignored; only the original request completes, with one cpuReady.
REQ-038 With CACHE_STATS_EN, the sequence in REQ-033 to REQ-035 -> hitCount=2, missCount=2.
